// File: rtl/mem_responder_pkg.sv
// Shared CPU-wide widths and the operation-level types used by the memory responder.
// lib_cpu must be compiled before lib_operation.
package lib_cpu;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 32;
endpackage

package lib_operation;
   localparam int unsigned STAGE = 2;

   typedef enum logic [STAGE-1:0] {
      FETCH    = 2'd0,
      DECODE   = 2'd1,
      EXECUTE  = 2'd2,
      MEMSTORE = 2'd3
   } stage_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_t;

   // Requests are refused when misaligned, beyond the store, issued from a
   // non-memory stage, or writing from anywhere but MEMSTORE.
   function automatic logic req_rejected(input logic [lib_cpu::ADDR_W-1:0] addr,
                                         input logic                       we,
                                         input stage_t                     stage,
                                         input int unsigned                depth);
      logic [lib_cpu::ADDR_W-1:0] word_idx;
      word_idx = addr >> 2;
      return (addr[1:0] != 2'b00) || (word_idx >= depth) ||
             (stage == DECODE) || (stage == EXECUTE) ||
             (we && (stage != MEMSTORE));
   endfunction
endpackage

// File: rtl/mem_responder_word_ram.sv
// Single-port word store: synchronous write, registered read that holds its
// value until the next read enable.
module word_ram
   import lib_cpu::*;
#(
   parameter int unsigned DEPTH = 256,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic            i_re,
   input  logic [AW-1:0]   i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rdata
);

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [XLEN-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then presents a response until it is consumed.
module mem_responder
   import lib_cpu::*;
   import lib_operation::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  stage_t            req_stage,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   resp_state_t     r_state;
   logic [3:0]      r_cnt;
   logic            r_we;
   logic            r_err;
   logic [AW-1:0]   r_idx;
   logic [XLEN-1:0] r_wdata;

   logic            w_accept;
   logic            w_req_err;
   logic            w_wait_done;
   logic            w_ram_we;
   logic            w_ram_re;
   logic [AW-1:0]   w_ram_addr;
   logic [XLEN-1:0] w_ram_wdata;
   logic [XLEN-1:0] w_ram_rdata;

   // Stage only matters through the error verdict, so the verdict is what gets
   // latched; the store address/data come straight from the request when idle.
   always_comb begin
      w_accept    = req_valid && (r_state == IDLE);
      w_req_err   = req_rejected(req_addr, req_we, req_stage, DEPTH);
      w_wait_done = (r_state == WAIT) && (r_cnt == 4'd0);
      w_ram_addr  = (r_state == IDLE) ? req_addr[AW+1:2] : r_idx;
      w_ram_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
      w_ram_re    = w_accept && !req_we;
      w_ram_we    = 1'b0;
      if (!rst) begin
         if (WAIT_CYCLES == 0) begin
            w_ram_we = w_accept && req_we && !w_req_err;
         end else begin
            w_ram_we = w_wait_done && r_we && !r_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_err   <= w_req_err;
                  r_idx   <= req_addr[AW+1:2];
                  r_wdata <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= RESP;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   word_ram #(
      .DEPTH (DEPTH)
   ) u_word_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_err   = resp_valid && r_err;
   assign resp_rdata = (resp_valid && !r_err && !r_we) ? w_ram_rdata : '0;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the backing store (power of two, >=4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0..15).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_stage, input, STAGE (2), the initiator's current stage (FETCH/DECODE/EXECUTE/MEMSTORE).
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, write data.
REQ-011 SHALL have port resp_valid, output, 1, response available.
REQ-012 SHALL have port resp_ready, input, 1, initiator consumes the response.
REQ-013 SHALL have port resp_rdata, output, 32, read data.
REQ-014 SHALL have port resp_err, output, 1, the request was rejected.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 A request SHALL be accepted on a cycle with req_valid && req_ready; addr, we, wdata and stage SHALL be latched that cycle.
REQ-017 On accept, the block SHALL go to RESP if WAIT_CYCLES = 0, else to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle and go to RESP on the cycle it reads 0; resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 In RESP, resp_valid = 1; resp_rdata and resp_err SHALL hold stable until resp_ready = 1, then go to IDLE on that edge.
REQ-020 The error condition SHALL be any of: addr[1:0] != 0; addr[31:2] >= DEPTH; stage DECODE or EXECUTE; we = 1 with stage != MEMSTORE.
REQ-021 A read SHALL return the word at addr[31:2]; writes and errored requests SHALL return resp_rdata = 0.
REQ-022 A write SHALL update the store on the edge entering RESP, exactly once, and only when no error is flagged.
REQ-023 req_valid during WAIT/RESP SHALL be ignored (not accepted, no side effect).
REQ-024 A new request SHALL NOT be accepted in the same cycle resp_ready completes a response; the earliest next accept is the following IDLE cycle.

Reset
REQ-025 On rst: state = IDLE, counter = 0, req_ready = 1 from the next cycle, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-026 rst during WAIT or RESP SHALL abort the transaction with no store write and no response.
REQ-027 Backing-store contents SHALL NOT be cleared by rst.

Structure
REQ-028 The responder state enum SHALL live in package lib_operation next to STAGE; the data and address widths SHALL come from lib_cpu.
REQ-029 The backing store SHALL be one sub-module, word_ram (single-port, synchronous write, DEPTH x 32).

Verification
REQ-030 Reset, WAIT_CYCLES=2, MEMSTORE write addr 0x10 data 0xDEADBEEF, then FETCH read 0x10 -> each resp_valid 3 cycles after accept, resp_err=0, read returns 0xDEADBEEF.
REQ-031 FETCH write addr 0x20 -> resp_err=1, resp_rdata=0; a subsequent MEMSTORE read of 0x20 returns the prior contents unchanged.
REQ-032 Reads at 0x13 (misaligned) and at 0x400 (DEPTH=256) -> resp_err=1; a DECODE read at 0x0 -> resp_err=1.
REQ-033 resp_ready held low for 5 cycles -> resp_valid, resp_rdata and resp_err stay constant and req_ready stays 0 while req_valid pulses.
REQ-034 rst asserted in WAIT of a MEMSTORE write of 0x55 to 0x8 -> no response; a later read of 0x8 returns the old value.
REQ-035 WAIT_CYCLES=0 -> resp_valid in the cycle after accept; back-to-back requests are accepted every 2 cycles with resp_ready tied high.
